// File: rtl/data_memory_responder.sv
// Data-side memory responder for the pipelined MIPS core: RAM plus PortIn/PortOut
// registers behind a req/ack handshake with WAIT_CYCLES programmable wait states.
module data_memory_responder #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEMORY_DEPTH = 1024,
    parameter int          WAIT_CYCLES  = 2,
    parameter logic [15:0] IN_ADDR      = 16'hFFF8,
    parameter logic [15:0] OUT_ADDR     = 16'hFFFC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Req,
    input  logic                  Write,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Ack,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  AddrErr,
    output logic                  Busy,
    input  logic [7:0]            PortIn,
    output logic [DATA_WIDTH-1:0] PortOut
);
    localparam int AW = $clog2(MEMORY_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q;
    logic [15:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] portout_q, portout_d;
    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    logic                  acc_go, acc_wr, mem_we;
    logic [15:0]           acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [AW-1:0]         idx;
    logic                  misal, is_in, is_out, in_ram;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^Address[31:16];

    // With zero wait states the access happens on the accept edge, so use live inputs.
    assign acc_wr    = (state_q == S_IDLE) ? Write          : wr_q;
    assign acc_addr  = (state_q == S_IDLE) ? Address[15:0]  : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? WriteData      : wdata_q;

    assign idx    = acc_addr[AW+1:2];
    assign misal  = |acc_addr[1:0];
    assign is_in  = (acc_addr == IN_ADDR);
    assign is_out = (acc_addr == OUT_ADDR);
    assign in_ram = ({1'b0, acc_addr} < 17'(4 * MEMORY_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            portout_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            portout_q <= portout_d;
            if (state_q == S_IDLE && Req) begin
                wr_q    <= Write;
                addr_q  <= Address[15:0];
                wdata_q <= WriteData;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_go  = 1'b0;
        case (state_q)
            S_IDLE: if (Req) begin
                if (WAIT_CYCLES == 0) begin
                    acc_go  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    acc_go  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (reset) acc_go = 1'b0;
    end

    always_comb begin
        rdata_d   = rdata_q;
        err_d     = err_q;
        portout_d = portout_q;
        mem_we    = 1'b0;
        ack_d     = acc_go;
        busy_d    = (state_d != S_IDLE);
        if (acc_go) begin
            if (misal) begin
                err_d   = 1'b1;
                rdata_d = '0;
            end else if (is_in) begin
                err_d = 1'b0;
                if (!acc_wr) rdata_d = {{(DATA_WIDTH-8){1'b0}}, PortIn};
            end else if (is_out) begin
                err_d = 1'b0;
                if (acc_wr) portout_d = acc_wdata;
                else        rdata_d   = portout_q;
            end else if (in_ram) begin
                err_d = 1'b0;
                if (acc_wr) mem_we  = 1'b1;
                else        rdata_d = mem[idx];
            end else begin
                err_d   = 1'b1;
                rdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= acc_wdata;
    end

    assign Ack      = ack_q;
    assign Busy     = busy_q;
    assign AddrErr  = err_q;
    assign ReadData = rdata_q;
    assign PortOut  = portout_q;
endmodule
